// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline: load-use and RAW stalls,
// branch flushes, memory-wait freezes, registered EX forwarding selects and event counters.
module hazard_fwd_ctrl #(
  parameter int CNT_W  = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_wr,
  input  logic             id_mem_rd,
  input  logic             ex_br_taken,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // wr already folds in valid, reg_wr and rd!=0, so x0 can never produce a match.
  typedef struct packed {
    logic       wr;
    logic [4:0] rd;
    logic       ld;
  } tag_t;

  // The WB producer is never compared: the regfile writes before it is read, and the
  // WB forwarding select is decided one stage earlier from the MEM tag.
  tag_t       ex_tag;
  logic       mem_wr;
  logic [4:0] mem_dst;

  logic a_ex, b_ex, a_mem, b_mem;
  logic load_use, hazard, freeze, flush, hz_stall, bubble;
  logic [1:0] fwd_a_nxt, fwd_b_nxt;
  tag_t id_tag;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    a_ex      = id_valid && id_use_rs1 && ex_tag.wr && (ex_tag.rd == id_rs1);
    b_ex      = id_valid && id_use_rs2 && ex_tag.wr && (ex_tag.rd == id_rs2);
    a_mem     = id_valid && id_use_rs1 && mem_wr && (mem_dst == id_rs1);
    b_mem     = id_valid && id_use_rs2 && mem_wr && (mem_dst == id_rs2);
    load_use  = (a_ex || b_ex) && ex_tag.ld;
    hazard    = FWD_EN ? load_use : (a_ex || b_ex || a_mem || b_mem);

    freeze    = mem_busy;
    flush     = !freeze && ex_br_taken;
    hz_stall  = !freeze && !ex_br_taken && hazard;
    bubble    = flush || hz_stall;

    id_tag.wr = id_valid && id_reg_wr && (id_rd != 5'd0);
    id_tag.rd = id_rd;
    id_tag.ld = id_mem_rd;

    fwd_a_nxt = 2'b00;
    fwd_b_nxt = 2'b00;
    if (FWD_EN && !bubble) begin
      if (a_ex)       fwd_a_nxt = 2'b01;
      else if (a_mem) fwd_a_nxt = 2'b10;
      if (b_ex)       fwd_b_nxt = 2'b01;
      else if (b_mem) fwd_b_nxt = 2'b10;
    end

    // Control outputs are gated by rst so an asynchronous reset silences them at once.
    stall_if  = !rst && (freeze || hz_stall);
    stall_id  = !rst && (freeze || hz_stall);
    flush_id  = !rst && flush;
    bubble_ex = !rst && bubble;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every stage shifts together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag    <= '0;
      mem_wr    <= 1'b0;
      mem_dst   <= 5'd0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!freeze) begin
      ex_tag    <= bubble ? '0 : id_tag;
      mem_wr    <= ex_tag.wr;
      mem_dst   <= ex_tag.rd;
      fwd_a_sel <= fwd_a_nxt;
      fwd_b_sel <= fwd_b_nxt;
      if (hz_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush && (flush_cnt != '1))    flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl: per-cycle expected outputs go through a scoreboard
// queue; one instance has forwarding enabled, the other has it disabled with 2-bit counters.
module tb_hazard_fwd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_wr, id_mem_rd;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_br_taken, mem_busy;

  logic        sif1, sid1, fl1, bub1;
  logic [1:0]  fa1, fb1;
  logic [15:0] sc1, fc1;
  logic        sif0, sid0, fl0, bub0;
  logic [1:0]  fa0, fb0;
  logic [1:0]  sc0, fc0;

  hazard_fwd_ctrl #(.CNT_W(16), .FWD_EN(1'b1)) dut_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .stall_if(sif1), .stall_id(sid1), .flush_id(fl1), .bubble_ex(bub1),
    .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_fwd_ctrl #(.CNT_W(2), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
    .stall_if(sif0), .stall_id(sid0), .flush_id(fl0), .bubble_ex(bub0),
    .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
  } instr_t;

  typedef struct packed {
    logic        sif;
    logic        sid;
    logic        fl;
    logic        bub;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return '{v: 1'b1, rs1: rs1, rs2: rs2, u1: 1'b1, u2: 1'b1, rd: rd, wr: 1'b1, ld: 1'b0};
  endfunction

  function automatic instr_t load(input logic [4:0] rd, input logic [4:0] rs1);
    return '{v: 1'b1, rs1: rs1, rs2: 5'd0, u1: 1'b1, u2: 1'b0, rd: rd, wr: 1'b1, ld: 1'b1};
  endfunction

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic exp_t ex(input logic sif, input logic sid, input logic fl, input logic bub,
                              input logic [1:0] fa, input logic [1:0] fb,
                              input int sc, input int fc);
    return '{sif: sif, sid: sid, fl: fl, bub: bub, fa: fa, fb: fb, sc: sc[15:0], fc: fc[15:0]};
  endfunction

  function automatic exp_t observe(input int which);
    if (which == 1) return '{sif: sif1, sid: sid1, fl: fl1, bub: bub1, fa: fa1, fb: fb1, sc: sc1, fc: fc1};
    return '{sif: sif0, sid: sid0, fl: fl0, bub: bub0, fa: fa0, fb: fb0, sc: {14'd0, sc0}, fc: {14'd0, fc0}};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic compare(input int which, input string tag);
    exp_t e, o;
    e = sb_q.pop_front();
    o = observe(which);
    check($sformatf("%s.stall_if", tag),  {31'd0, o.sif}, {31'd0, e.sif});
    check($sformatf("%s.stall_id", tag),  {31'd0, o.sid}, {31'd0, e.sid});
    check($sformatf("%s.flush_id", tag),  {31'd0, o.fl},  {31'd0, e.fl});
    check($sformatf("%s.bubble_ex", tag), {31'd0, o.bub}, {31'd0, e.bub});
    check($sformatf("%s.fwd_a_sel", tag), {30'd0, o.fa},  {30'd0, e.fa});
    check($sformatf("%s.fwd_b_sel", tag), {30'd0, o.fb},  {30'd0, e.fb});
    check($sformatf("%s.stall_cnt", tag), {16'd0, o.sc},  {16'd0, e.sc});
    check($sformatf("%s.flush_cnt", tag), {16'd0, o.fc},  {16'd0, e.fc});
  endtask

  task automatic drive(input instr_t i, input logic br, input logic busy);
    id_valid    = i.v;
    id_rs1      = i.rs1;
    id_rs2      = i.rs2;
    id_use_rs1  = i.u1;
    id_use_rs2  = i.u2;
    id_rd       = i.rd;
    id_reg_wr   = i.wr;
    id_mem_rd   = i.ld;
    ex_br_taken = br;
    mem_busy    = busy;
  endtask

  // Drive on the falling edge, record the expectation, compare once outputs have settled.
  task automatic step(input string tag, input int which, input instr_t i,
                      input logic br, input logic busy, input exp_t e);
    @(negedge clk);
    drive(i, br, busy);
    sb_q.push_back(e);
    #1;
    compare(which, tag);
  endtask

  initial begin
    // Reset: outputs stay quiet even with busy/branch/hazard inputs active.
    drive(alu(5'd3, 5'd1, 5'd2), 1'b1, 1'b1);
    @(negedge clk);
    sb_q.push_back(ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    sb_q.push_back(ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    #1;
    compare(1, "rst_fwd");
    compare(0, "rst_nofwd");
    @(negedge clk);
    drive(nop(), 1'b0, 1'b0);
    rst = 1'b0;

    // Back-to-back ALU RAW with forwarding.
    step("c0",  1, alu(5'd5, 5'd1, 5'd2),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    step("c1",  1, alu(5'd6, 5'd5, 5'd3),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    step("c2",  1, alu(5'd7, 5'd4, 5'd5),   0, 0, ex(0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
    step("c3",  1, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b10, 0, 0));
    // x0 destination never forwards.
    step("c4",  1, alu(5'd0, 5'd1, 5'd1),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    step("c5",  1, alu(5'd20, 5'd0, 5'd0),  0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    step("c6",  1, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    // Load-use: one bubble, then WB forward on operand B.
    step("c7",  1, load(5'd7, 5'd1),        0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    step("c8",  1, alu(5'd8, 5'd1, 5'd7),   0, 0, ex(1, 1, 0, 1, 2'b00, 2'b00, 0, 0));
    step("c9",  1, alu(5'd8, 5'd1, 5'd7),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
    step("c10", 1, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b10, 1, 0));
    // Taken branch overrides a pending load-use.
    step("c11", 1, load(5'd9, 5'd1),        0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 1, 0));
    step("c12", 1, alu(5'd10, 5'd9, 5'd9),  1, 0, ex(0, 0, 1, 1, 2'b00, 2'b00, 1, 0));
    step("c13", 1, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 1, 1));
    // mem_busy for three cycles during a load-use, stall follows the release.
    step("c14", 1, load(5'd11, 5'd1),       0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 1, 1));
    step("c15", 1, alu(5'd12, 5'd11, 5'd2), 0, 1, ex(1, 1, 0, 0, 2'b00, 2'b00, 1, 1));
    step("c16", 1, alu(5'd12, 5'd11, 5'd2), 0, 1, ex(1, 1, 0, 0, 2'b00, 2'b00, 1, 1));
    step("c17", 1, alu(5'd12, 5'd11, 5'd2), 0, 1, ex(1, 1, 0, 0, 2'b00, 2'b00, 1, 1));
    step("c18", 1, alu(5'd12, 5'd11, 5'd2), 0, 0, ex(1, 1, 0, 1, 2'b00, 2'b00, 1, 1));
    step("c19", 1, alu(5'd12, 5'd11, 5'd2), 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 2, 1));
    step("c20", 1, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b10, 2'b00, 2, 1));
    // mem_busy outranks a taken branch; the branch acts after release.
    step("c21", 1, nop(),                   1, 1, ex(1, 1, 0, 0, 2'b00, 2'b00, 2, 1));
    step("c22", 1, nop(),                   1, 0, ex(0, 0, 1, 1, 2'b00, 2'b00, 2, 1));
    step("c23", 1, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 2, 2));
    // An invalid ID slot produces no hazard and enters EX as invalid.
    begin
      instr_t inv;
      inv   = alu(5'd13, 5'd1, 5'd1);
      inv.v = 1'b0;
      step("c24", 1, inv,                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 2, 2));
    end
    step("c25", 1, alu(5'd14, 5'd13, 5'd13), 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 2, 2));
    step("c26", 1, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 2, 2));

    // Forwarding disabled: fresh reset, then RAW stalls until the producer reaches WB.
    @(negedge clk);
    drive(nop(), 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step("d0",  0, alu(5'd5, 5'd1, 5'd2),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    step("d1",  0, alu(5'd6, 5'd5, 5'd3),   0, 0, ex(1, 1, 0, 1, 2'b00, 2'b00, 0, 0));
    step("d2",  0, alu(5'd6, 5'd5, 5'd3),   0, 0, ex(1, 1, 0, 1, 2'b00, 2'b00, 1, 0));
    step("d3",  0, alu(5'd6, 5'd5, 5'd3),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 2, 0));
    step("d4",  0, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 2, 0));
    step("d5",  0, alu(5'd7, 5'd6, 5'd3),   0, 0, ex(1, 1, 0, 1, 2'b00, 2'b00, 2, 0));
    step("d6",  0, alu(5'd7, 5'd6, 5'd3),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 3, 0));
    // Stall counter saturates at 3.
    step("d7",  0, alu(5'd8, 5'd7, 5'd3),   0, 0, ex(1, 1, 0, 1, 2'b00, 2'b00, 3, 0));
    step("d8",  0, alu(5'd8, 5'd7, 5'd3),   0, 0, ex(1, 1, 0, 1, 2'b00, 2'b00, 3, 0));
    step("d9",  0, alu(5'd8, 5'd7, 5'd3),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 3, 0));
    // Flush counter saturates at 3.
    for (int k = 0; k < 4; k++)
      step($sformatf("d_br%0d", k), 0, nop(), 1, 0, ex(0, 0, 1, 1, 2'b00, 2'b00, 3, k));
    step("d14", 0, nop(),                   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 3, 3));
    // Asynchronous reset in the middle of a stall clears everything without a clock edge.
    step("d15", 0, alu(5'd9, 5'd1, 5'd2),   0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 3, 3));
    step("d16", 0, alu(5'd10, 5'd9, 5'd3),  0, 0, ex(1, 1, 0, 1, 2'b00, 2'b00, 3, 3));
    rst = 1'b1;
    sb_q.push_back(ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
    #1;
    compare(0, "d_async_rst");
    @(negedge clk);
    rst = 1'b0;
    step("d17", 0, alu(5'd10, 5'd9, 5'd3),  0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
